// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
// Defining MWADD_SUB_EN adds the op_sub request bit.
interface multiword_add_seq_if #(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 4
);
    localparam int TW = WIDTH * NWORDS;

    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] op_a;
    logic [TW-1:0] op_b;
    logic          cin;
`ifdef MWADD_SUB_EN
    logic          op_sub;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] sum;
    logic          cout;
    logic          busy;

    modport master (
`ifdef MWADD_SUB_EN
        output op_sub,
`endif
        output in_valid, op_a, op_b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
`ifdef MWADD_SUB_EN
        input  op_sub,
`endif
        input  in_valid, op_a, op_b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Wide adder that reuses one WIDTH-bit ripple-carry adder, one word per cycle, LSW first.
// Defining MWADD_SUB_EN enables op_a - op_b via op_sub (cout=1 means no borrow).
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_c[WIDTH];
endmodule

module multiword_add_seq #(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multiword_add_seq_if.slave  bus
);
    localparam int TW = WIDTH * NWORDS;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                   r_state;
    logic [IW-1:0]                r_idx;
    logic                         r_carry;
    logic [TW-1:0]                r_op_a;
    logic [TW-1:0]                r_op_b;
    logic                         r_cout;
    logic [NWORDS-1:0][WIDTH-1:0] r_sum_words;
`ifdef MWADD_SUB_EN
    logic                         r_op_sub;
`endif

    logic [WIDTH-1:0] w_a_word;
    logic [WIDTH-1:0] w_b_raw;
    logic [WIDTH-1:0] w_b_word;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_init_carry;

    assign w_a_word = r_op_a[32'(r_idx) * WIDTH +: WIDTH];
    assign w_b_raw  = r_op_b[32'(r_idx) * WIDTH +: WIDTH];

`ifdef MWADD_SUB_EN
    // Subtraction is a + ~b + 1; the forced initial carry supplies the +1.
    assign w_b_word     = r_op_sub ? ~w_b_raw : w_b_raw;
    assign w_init_carry = bus.op_sub ? 1'b1 : bus.cin;
`else
    assign w_b_word     = w_b_raw;
    assign w_init_carry = bus.cin;
`endif

    ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
`ifdef MWADD_SUB_EN
            r_op_sub <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op_a  <= bus.op_a;
                        r_op_b  <= bus.op_b;
`ifdef MWADD_SUB_EN
                        r_op_sub <= bus.op_sub;
`endif
                        r_idx   <= '0;
                        r_carry <= w_init_carry;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry <= w_cout;
                    // idx stays parked at the last word so it never wraps.
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_cout;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum_words <= '0;
        end else if (r_state == S_RUN) begin
            for (int w = 0; w < NWORDS; w++) begin
                if (r_idx == IW'(w)) begin
                    r_sum_words[w] <= w_sum;
                end
            end
        end
    end

    assign bus.in_ready  = rst_n && (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.sum       = r_sum_words;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed and randomized checks of multiword_add_seq against a plain-arithmetic model.
// Subtraction cases are exercised when MWADD_SUB_EN is defined.
module tb_multiword_add_seq;
    localparam int WIDTH  = 4;
    localparam int NWORDS = 4;
    localparam int TW     = WIDTH * NWORDS;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multiword_add_seq_if #(.WIDTH(WIDTH), .NWORDS(NWORDS)) bus ();

    multiword_add_seq #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [TW:0] ref_calc(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                             input logic c, input logic s);
        logic [TW:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + (TW+1)'(1);
        else   r = {1'b0, a} + {1'b0, b} + (TW+1)'(c);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sub(input logic s);
`ifdef MWADD_SUB_EN
        bus.op_sub = s;
`else
        if (s) $display("note: subtract request ignored (add-only build)");
`endif
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c, input logic s);
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.op_a = a; bus.op_b = b; bus.cin = c; drive_sub(s);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_a = $urandom; bus.op_b = $urandom; bus.cin = ~c; drive_sub(~s);
    endtask

    task automatic wait_done(input string tag, input logic [TW-1:0] exp_sum, input logic exp_cout);
        int lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NWORDS));
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        $display("txn %s: sum=%h cout=%0b latency=%0d", tag, bus.sum, bus.cout, lat);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [TW-1:0] a, input logic [TW-1:0] b,
                          input logic c, input logic s, input int hold);
        logic [TW:0] exp;
        exp = ref_calc(a, b, c, s);
        send(a, b, c, s);
        wait_done(tag, exp[TW-1:0], exp[TW]);
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_sum"}, 32'(bus.sum), 32'(exp[TW-1:0]));
        end
        release_result(tag);
    endtask

    initial begin
        logic [TW-1:0] held_sum;
        logic          held_cout;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0; drive_sub(1'b0);
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_op("add_1234_1111", 16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op("add_0_0_cin", 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
        run_op("add_8000_8000_cin", 16'h8000, 16'h8000, 1'b1, 1'b0, 0);

        // Backpressure in DONE while in_valid is pulsed.
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        wait_done("bp", 16'h1010, 1'b0);
        held_sum = bus.sum; held_cout = bus.cout;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.op_a = $urandom; bus.op_b = $urandom; bus.cin = 1'b1;
            @(negedge clk);
            check("bp_sum_stable", 32'(bus.sum), 32'(held_sum));
            check("bp_cout_stable", 32'(bus.cout), 32'(held_cout));
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        release_result("bp");
        run_op("after_bp", 16'h0003, 16'h0004, 1'b0, 1'b0, 0);

        // Reset while the third word is being processed.
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_in_ready_low", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_release", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < NWORDS + 2; i++) begin
            check("midrst_no_out_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        run_op("after_rst_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

`ifdef MWADD_SUB_EN
        run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

        for (int i = 0; i < 24; i++) begin
            logic s;
`ifdef MWADD_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run_op($sformatf("rand%0d", i), TW'($urandom), TW'($urandom),
                   1'($urandom_range(0, 1)), s, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
